cnn_stream_ctrl: RTL and testbench

Multi-channel frame-timing controller for the CNN datapath; successor to the single-frame cnn_ctrl FSM. It generates vsync/hsync blanking windows and the data-run strobe, plus row/col/channel coordinates for the line buffers and DMA. Additions over cnn_ctrl: it sequences q_num_ch back-to-back frames, honours downstream back-pressure (i_ready), supports a continuous mode with graceful stop, and lets either delay be zero.

---
 rtl/cnn_stream_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_cnn_stream_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_stream_ctrl.sv
// Multi-channel frame-timing controller: sequences vsync/hsync blanking and
// pixel beats over q_num_ch frames, with back-pressure, continuous mode and stop.
module cnn_stream_ctrl #(
    parameter int W_SIZE       = 12,
    parameter int W_FRAME_SIZE = 2*W_SIZE+1,
    parameter int W_DELAY      = 12,
    parameter int W_CH         = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [W_SIZE-1:0]       q_width,
    input  logic [W_SIZE-1:0]       q_height,
    input  logic [W_DELAY-1:0]      q_vsync_delay,
    input  logic [W_DELAY-1:0]      q_hsync_delay,
    input  logic [W_CH-1:0]         q_num_ch,
    input  logic                    q_continuous,
    input  logic                    q_start,
    input  logic                    q_stop,
    input  logic                    i_ready,
    output logic                    o_ctrl_vsync_run,
    output logic [W_DELAY-1:0]      o_ctrl_vsync_cnt,
    output logic                    o_ctrl_hsync_run,
    output logic [W_DELAY-1:0]      o_ctrl_hsync_cnt,
    output logic                    o_ctrl_data_run,
    output logic [W_SIZE-1:0]       o_row,
    output logic [W_SIZE-1:0]       o_col,
    output logic [W_CH-1:0]         o_ch,
    output logic [W_FRAME_SIZE-1:0] o_data_count,
    output logic                    o_end_line,
    output logic                    o_end_frame,
    output logic                    o_busy,
    output logic                    o_done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] VSYNC = 3'd1;
    localparam logic [2:0] HSYNC = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]              state_q, state_d;
    logic                    startPrev_q;
    logic                    stop_q, stop_d;
    logic [W_SIZE-1:0]       width_q, height_q;
    logic [W_DELAY-1:0]      vsDly_q, hsDly_q;
    logic [W_CH-1:0]         numCh_q;
    logic                    cont_q;
    logic [W_DELAY-1:0]      vsCnt_q, vsCnt_d;
    logic [W_DELAY-1:0]      hsCnt_q, hsCnt_d;
    logic [W_SIZE-1:0]       row_q, row_d;
    logic [W_SIZE-1:0]       col_q, col_d;
    logic [W_CH-1:0]         ch_q, ch_d;
    logic [W_FRAME_SIZE-1:0] dataCount_q, dataCount_d;

    logic       startEdge, cfgValid, loadCfg;
    logic       beat, lastCol, lastRow, endLine, endFrame, stopNow;
    logic [2:0] frameStart, lineStart;

    assign startEdge  = q_start & ~startPrev_q;
    assign cfgValid   = (q_width != '0) && (q_height != '0) && (q_num_ch != '0);
    assign loadCfg    = (state_q == IDLE) && startEdge && cfgValid;
    assign beat       = (state_q == DATA) && i_ready;
    assign lastCol    = (col_q == width_q - W_SIZE'(1));
    assign lastRow    = (row_q == height_q - W_SIZE'(1));
    assign endLine    = beat && lastCol;
    assign endFrame   = endLine && lastRow;
    assign stopNow    = stop_q | q_stop;
    assign lineStart  = (hsDly_q != '0) ? HSYNC : DATA;
    assign frameStart = (vsDly_q != '0) ? VSYNC : lineStart;

    // Next-state logic; zero-length blanking windows are skipped entirely.
    always_comb begin
        state_d     = state_q;
        vsCnt_d     = vsCnt_q;
        hsCnt_d     = hsCnt_q;
        row_d       = row_q;
        col_d       = col_q;
        ch_d        = ch_q;
        dataCount_d = dataCount_q;
        stop_d      = (state_q == IDLE) ? 1'b0 : (stop_q | q_stop);

        case (state_q)
            IDLE: begin
                if (loadCfg) begin
                    if (q_vsync_delay != '0)      state_d = VSYNC;
                    else if (q_hsync_delay != '0) state_d = HSYNC;
                    else                          state_d = DATA;
                end
            end
            VSYNC: begin
                if (vsCnt_q == vsDly_q - W_DELAY'(1)) begin
                    vsCnt_d = '0;
                    state_d = lineStart;
                end else begin
                    vsCnt_d = vsCnt_q + W_DELAY'(1);
                end
            end
            HSYNC: begin
                if (hsCnt_q == hsDly_q - W_DELAY'(1)) begin
                    hsCnt_d = '0;
                    state_d = DATA;
                end else begin
                    hsCnt_d = hsCnt_q + W_DELAY'(1);
                end
            end
            DATA: begin
                if (beat) begin
                    if (lastCol) begin
                        col_d = '0;
                        if (lastRow) begin
                            row_d       = '0;
                            dataCount_d = '0;
                            if ((ch_q < numCh_q - W_CH'(1)) && !stopNow) begin
                                ch_d    = ch_q + W_CH'(1);
                                state_d = frameStart;
                            end else if (cont_q && !stopNow) begin
                                ch_d    = '0;
                                state_d = frameStart;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            row_d       = row_q + W_SIZE'(1);
                            dataCount_d = dataCount_q + W_FRAME_SIZE'(1);
                            state_d     = lineStart;
                        end
                    end else begin
                        col_d       = col_q + W_SIZE'(1);
                        dataCount_d = dataCount_q + W_FRAME_SIZE'(1);
                    end
                end
            end
            DONE: begin
                ch_d    = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            startPrev_q <= 1'b0;
            stop_q      <= 1'b0;
            width_q     <= '0;
            height_q    <= '0;
            vsDly_q     <= '0;
            hsDly_q     <= '0;
            numCh_q     <= '0;
            cont_q      <= 1'b0;
            vsCnt_q     <= '0;
            hsCnt_q     <= '0;
            row_q       <= '0;
            col_q       <= '0;
            ch_q        <= '0;
            dataCount_q <= '0;
        end else begin
            state_q     <= state_d;
            startPrev_q <= q_start;
            stop_q      <= stop_d;
            vsCnt_q     <= vsCnt_d;
            hsCnt_q     <= hsCnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            ch_q        <= ch_d;
            dataCount_q <= dataCount_d;
            if (loadCfg) begin
                width_q  <= q_width;
                height_q <= q_height;
                vsDly_q  <= q_vsync_delay;
                hsDly_q  <= q_hsync_delay;
                numCh_q  <= q_num_ch;
                cont_q   <= q_continuous;
            end
        end
    end

    assign o_ctrl_vsync_run = (state_q == VSYNC);
    assign o_ctrl_vsync_cnt = vsCnt_q;
    assign o_ctrl_hsync_run = (state_q == HSYNC);
    assign o_ctrl_hsync_cnt = hsCnt_q;
    assign o_ctrl_data_run  = beat;
    assign o_row            = row_q;
    assign o_col            = col_q;
    assign o_ch             = ch_q;
    assign o_data_count     = dataCount_q;
    assign o_end_line       = endLine;
    assign o_end_frame      = endFrame;
    assign o_busy           = (state_q != IDLE);
    assign o_done           = (state_q == DONE);

endmodule

// File: tb/tb_cnn_stream_ctrl.sv
// Scoreboard bench for cnn_stream_ctrl: expected beats are queued per run from
// plain frame arithmetic and a negedge monitor checks every DUT beat and pulse.
module tb_cnn_stream_ctrl;

    localparam int W_SIZE       = 12;
    localparam int W_FRAME_SIZE = 2*W_SIZE+1;
    localparam int W_DELAY      = 12;
    localparam int W_CH         = 4;

    logic                    clk;
    logic                    rstn;
    logic [W_SIZE-1:0]       q_width, q_height;
    logic [W_DELAY-1:0]      q_vsync_delay, q_hsync_delay;
    logic [W_CH-1:0]         q_num_ch;
    logic                    q_continuous, q_start, q_stop, i_ready;
    logic                    o_ctrl_vsync_run, o_ctrl_hsync_run, o_ctrl_data_run;
    logic [W_DELAY-1:0]      o_ctrl_vsync_cnt, o_ctrl_hsync_cnt;
    logic [W_SIZE-1:0]       o_row, o_col;
    logic [W_CH-1:0]         o_ch;
    logic [W_FRAME_SIZE-1:0] o_data_count;
    logic                    o_end_line, o_end_frame, o_busy, o_done;

    cnn_stream_ctrl #(
        .W_SIZE(W_SIZE), .W_FRAME_SIZE(W_FRAME_SIZE), .W_DELAY(W_DELAY), .W_CH(W_CH)
    ) dut (
        .clk(clk), .rstn(rstn),
        .q_width(q_width), .q_height(q_height),
        .q_vsync_delay(q_vsync_delay), .q_hsync_delay(q_hsync_delay),
        .q_num_ch(q_num_ch), .q_continuous(q_continuous),
        .q_start(q_start), .q_stop(q_stop), .i_ready(i_ready),
        .o_ctrl_vsync_run(o_ctrl_vsync_run), .o_ctrl_vsync_cnt(o_ctrl_vsync_cnt),
        .o_ctrl_hsync_run(o_ctrl_hsync_run), .o_ctrl_hsync_cnt(o_ctrl_hsync_cnt),
        .o_ctrl_data_run(o_ctrl_data_run),
        .o_row(o_row), .o_col(o_col), .o_ch(o_ch), .o_data_count(o_data_count),
        .o_end_line(o_end_line), .o_end_frame(o_end_frame),
        .o_busy(o_busy), .o_done(o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int doneExpect = 0;
    int doneSeen = 0;
    int popped = 0;
    int busyCycles = 0;
    int curVd = 0;
    int curHd = 0;
    int vLen = 0;
    int hLen = 0;
    logic [54:0] expQ[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Beat order of a frame follows directly from raster scan arithmetic.
    task automatic pushFrame(input int w, input int h, input int ch);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                expQ.push_back({W_SIZE'(r), W_SIZE'(c), W_CH'(ch), W_FRAME_SIZE'(r*w + c),
                                (c == w-1), (c == w-1) && (r == h-1)});
            end
        end
    endtask

    task automatic setConfig(input int w, input int h, input int vd, input int hd,
                             input int nch, input logic cont);
        q_width       = W_SIZE'(w);
        q_height      = W_SIZE'(h);
        q_vsync_delay = W_DELAY'(vd);
        q_hsync_delay = W_DELAY'(hd);
        q_num_ch      = W_CH'(nch);
        q_continuous  = cont;
        curVd         = vd;
        curHd         = hd;
    endtask

    task automatic scrambleConfig();
        q_width       = W_SIZE'($urandom_range(0, 4095));
        q_height      = W_SIZE'($urandom_range(0, 4095));
        q_vsync_delay = W_DELAY'($urandom_range(0, 4095));
        q_hsync_delay = W_DELAY'($urandom_range(0, 4095));
        q_num_ch      = W_CH'($urandom_range(0, 15));
        q_continuous  = 1'($urandom_range(0, 1));
    endtask

    // readyMode: 0 = always ready, 1 = random back-pressure, 2 = 3-cycle stall at beat 6
    task automatic applyStimulus(input int w, input int h, input int vd, input int hd,
                                 input int nch, input int readyMode, input bit holdStart);
        int startSeen, cycles, stalls, limit, frameCycles;
        setConfig(w, h, vd, hd, nch, 1'b0);
        for (int c = 0; c < nch; c++) pushFrame(w, h, c);
        frameCycles = vd + h*(hd + w);
        limit = 200 + 8*nch*frameCycles;
        doneExpect++;
        startSeen = doneSeen;
        stalls = 0;
        cycles = 0;
        @(posedge clk); #1;
        busyCycles = 0;
        popped = 0;
        i_ready = 1'b1;
        q_start = 1'b1;
        @(posedge clk); #1;
        if (!holdStart) q_start = 1'b0;
        scrambleConfig();
        while (doneSeen == startSeen && cycles < limit) begin
            if (readyMode == 1) begin
                i_ready = ($urandom_range(0, 3) != 0);
            end else if (readyMode == 2 && popped == 6 && stalls < 3) begin
                i_ready = 1'b0;
                stalls++;
                checkOutput("stallCol", 64'(o_col), 64'd2);
                checkOutput("stallCount", 64'(o_data_count), 64'd6);
            end else begin
                i_ready = 1'b1;
            end
            @(posedge clk); #1;
            cycles++;
        end
        if (cycles >= limit) checkOutput("runTimeout", 64'(cycles), 64'(limit - 1));
        checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
        if (readyMode != 1)
            checkOutput("busyCycles", 64'(busyCycles),
                        64'(nch*frameCycles + 1 + ((readyMode == 2) ? 3 : 0)));
        i_ready = 1'b1;
    endtask

    task automatic applyContinuousStop();
        int startSeen, cycles;
        bit stopped;
        setConfig(3, 2, 1, 1, 2, 1'b1);
        pushFrame(3, 2, 0);
        pushFrame(3, 2, 1);
        pushFrame(3, 2, 0);
        doneExpect++;
        startSeen = doneSeen;
        stopped = 0;
        cycles = 0;
        @(posedge clk); #1;
        q_start = 1'b1;
        @(posedge clk); #1;
        q_start = 1'b0;
        scrambleConfig();
        while (doneSeen == startSeen && cycles < 500) begin
            i_ready = ($urandom_range(0, 3) != 0);
            q_stop = 1'b0;
            if (!stopped && expQ.size() <= 3) begin
                q_stop = 1'b1;
                stopped = 1;
            end
            @(posedge clk); #1;
            cycles++;
        end
        q_stop = 1'b0;
        if (cycles >= 500) checkOutput("contTimeout", 64'(cycles), 64'd499);
        checkOutput("contQueueEmpty", 64'(expQ.size()), 64'd0);
        i_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("contIdleAfterStop", 64'(o_busy), 64'd0);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput(name, {o_ctrl_vsync_run, o_ctrl_vsync_cnt, o_ctrl_hsync_run, o_ctrl_hsync_cnt,
                           o_ctrl_data_run, o_row, o_col, o_ch, o_data_count,
                           o_end_line, o_end_frame, o_busy, o_done}, 64'd0);
    endtask

    task automatic applyMidReset();
        int cycles;
        setConfig(4, 3, 2, 1, 1, 1'b0);
        pushFrame(4, 3, 0);
        doneExpect++;
        popped = 0;
        cycles = 0;
        @(posedge clk); #1;
        q_start = 1'b1;
        @(posedge clk); #1;
        q_start = 1'b0;
        while (popped < 5 && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("resetReachRow1", 64'(o_row), 64'd1);
        rstn = 1'b0;
        @(posedge clk); #1;
        checkAllZero("midResetOutputs");
        rstn = 1'b1;
        expQ.delete();
        doneExpect = 0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("postResetBusy", 64'(o_busy), 64'd0);
    endtask

    task automatic applyInvalid(input int w, input int h, input int nch);
        setConfig(w, h, 2, 2, nch, 1'b0);
        @(posedge clk); #1;
        q_start = 1'b1;
        @(posedge clk); #1;
        q_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checkOutput("invalidBusy", 64'(o_busy), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    // Monitor: pops one expected beat per accepted pixel and checks blanking windows.
    always @(negedge clk) begin
        logic [54:0] expBeat;
        if (o_busy) busyCycles++;
        if (o_ctrl_data_run) begin
            if (expQ.size() == 0) begin
                checkOutput("extraBeat", 64'(o_data_count), 64'h1_0000_0000);
            end else begin
                expBeat = expQ.pop_front();
                checkOutput("beat", {o_row, o_col, o_ch, o_data_count, o_end_line, o_end_frame}, expBeat);
                popped++;
            end
        end else if (o_end_line || o_end_frame) begin
            checkOutput("strayEnd", {o_end_line, o_end_frame}, 64'd0);
        end
        if (o_done) begin
            checkOutput("donePulse", 64'((doneExpect > 0) && (expQ.size() == 0)), 64'd1);
            if (doneExpect > 0) doneExpect--;
            doneSeen++;
        end
        if (o_ctrl_vsync_run) begin
            checkOutput("vsyncCnt", 64'(o_ctrl_vsync_cnt), 64'(vLen));
            vLen++;
        end else begin
            if (vLen != 0) checkOutput("vsyncLen", 64'(vLen), 64'(curVd));
            vLen = 0;
            if (o_ctrl_vsync_cnt != '0) checkOutput("vsyncCntIdle", 64'(o_ctrl_vsync_cnt), 64'd0);
        end
        if (o_ctrl_hsync_run) begin
            checkOutput("hsyncCnt", 64'(o_ctrl_hsync_cnt), 64'(hLen));
            hLen++;
        end else begin
            if (hLen != 0) checkOutput("hsyncLen", 64'(hLen), 64'(curHd));
            hLen = 0;
            if (o_ctrl_hsync_cnt != '0) checkOutput("hsyncCntIdle", 64'(o_ctrl_hsync_cnt), 64'd0);
        end
    end

    initial begin
        rstn = 1'b0;
        q_start = 1'b0;
        q_stop = 1'b0;
        i_ready = 1'b1;
        setConfig(0, 0, 0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("resetOutputs");
        rstn = 1'b1;
        @(posedge clk); #1;

        $display("[TB] basic two-channel run");
        applyStimulus(4, 3, 5, 2, 2, 0, 1'b0);
        $display("[TB] stall at row1 col2");
        applyStimulus(4, 3, 5, 2, 2, 2, 1'b0);
        $display("[TB] zero-delay 128x128 frame");
        applyStimulus(128, 128, 0, 0, 1, 0, 1'b0);
        $display("[TB] continuous mode with stop");
        applyContinuousStop();
        $display("[TB] reset mid-frame then rerun");
        applyMidReset();
        applyStimulus(4, 3, 2, 1, 1, 0, 1'b0);
        $display("[TB] invalid configs");
        applyInvalid(0, 3, 1);
        applyInvalid(4, 0, 1);
        applyInvalid(4, 3, 0);
        $display("[TB] start held high");
        applyStimulus(3, 2, 1, 0, 1, 0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("heldStartBusy", 64'(o_busy), 64'd0);
            @(posedge clk); #1;
        end
        q_start = 1'b0;
        $display("[TB] randomized runs");
        for (int i = 0; i < 8; i++) begin
            applyStimulus($urandom_range(1, 6), $urandom_range(1, 5), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(1, 3), 1, 1'b0);
        end
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
